window_sr_ctrl: RTL

- Stream controller for the sliding-window shift register (parallel-out rows chained through RAM row delays).
- Accepts one 8-bit pixel per handshake in raster order and drives the window register's shift data and shift enable.
- Tracks image position and flags cycles where the parallel window holds a complete, non-wrapping WIN_W x WIN_H patch.
- Holds the window stable under downstream backpressure.
- The window register used with this block advances only on cycles where sr_shift_en=1.
- RAM row-delay depth is fixed at IMG_WIDTH-WIN_W.

---
 rtl/window_sr_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/window_sr_ctrl.sv
// Stream controller for a sliding-window shift register.
// Accepts raster-order pixels, drives the window register's shift port,
// tracks the image position and flags cycles where the parallel window
// holds a complete, non-wrapping WIN_W x WIN_H patch. Under downstream
// backpressure the window register is frozen so the patch stays stable.
module window_sr_ctrl #(
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28,
    parameter int WIN_W      = 3,
    parameter int WIN_H      = 3,
    parameter int CW         = $clog2(IMG_WIDTH),
    parameter int RW         = $clog2(IMG_HEIGHT)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    input  logic          in_sof,
    output logic          in_ready,
    output logic [7:0]    sr_shift_in,
    output logic          sr_shift_en,
    output logic          win_valid,
    output logic [RW-1:0] win_row,
    output logic [CW-1:0] win_col,
    input  logic          out_ready,
    output logic          frame_done,
    output logic          sof_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,  // waiting for a start-of-frame pixel
        ACTIVE = 2'd1,  // streaming the frame
        DRAIN  = 2'd2   // all pixels in, waiting for the last window to be taken
    } state_t;

    // Exact counter limits and the first position at which a patch is complete.
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_QUAL = CW'(WIN_W - 1);
    localparam logic [RW-1:0] ROW_QUAL = RW'(WIN_H - 1);

    state_t        state;
    state_t        state_next;

    // Position of the next pixel expected in raster order.
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // Position assigned to the pixel accepted this cycle; a start-of-frame
    // pixel always lands at (0,0) regardless of the running counters.
    logic [CW-1:0] pos_col;
    logic [RW-1:0] pos_row;

    logic          shift;      // pixel accepted and pushed into the window register
    logic          discard;    // pixel accepted in IDLE without in_sof: dropped
    logic          restart;    // in_sof accepted mid-frame: counters restart
    logic          take;       // consumer takes the current window
    logic          stall;      // pending window not yet taken
    logic          last_pix;   // accepted pixel is the bottom-right of the frame
    logic          qualify;    // accepted pixel completes a non-wrapping patch
    logic          frame_end;  // last window of the frame handed off

    assign take        = win_valid & out_ready;
    assign stall       = win_valid & ~out_ready;
    assign sr_shift_in = in_data;
    assign sr_shift_en = shift;

    assign last_pix = (pos_col == COL_LAST) && (pos_row == ROW_LAST);
    assign qualify  = shift && (pos_row >= ROW_QUAL) && (pos_col >= COL_QUAL);

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking (=) is reserved for combinational logic.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, handshake and pixel-position decode.
    // NOTE: every output of this block is given a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        shift      = 1'b0;
        discard    = 1'b0;
        restart    = 1'b0;
        frame_end  = 1'b0;
        pos_col    = col;
        pos_row    = row;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_sof) begin
                        shift   = 1'b1;
                        pos_col = '0;
                        pos_row = '0;
                    end else begin
                        discard = 1'b1;
                    end
                end
            end

            ACTIVE: begin
                // Freeze the window register while a patch awaits the consumer.
                in_ready = ~stall;
                if (in_valid && !stall) begin
                    shift = 1'b1;
                    if (in_sof) begin
                        restart = 1'b1;
                        pos_col = '0;
                        pos_row = '0;
                    end
                end
            end

            DRAIN: begin
                // The final pixel always completes a patch; leave once it is taken.
                if (take || !win_valid) begin
                    frame_end  = 1'b1;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        if (shift) begin
            state_next = last_pix ? DRAIN : ACTIVE;
        end
    end

    // Raster position counters: advance on every shifted pixel, wrapping
    // column into row and row back to zero at the frame end.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (shift) begin
            if (pos_col == COL_LAST) begin
                col <= '0;
                row <= (pos_row == ROW_LAST) ? '0 : pos_row + RW'(1);
            end else begin
                col <= pos_col + CW'(1);
                row <= pos_row;
            end
        end
    end

    // Window-valid flag and top-left coordinates, aligned with the shifted
    // register contents one cycle after the qualifying accept.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
        end else if (qualify) begin
            win_valid <= 1'b1;
            win_row   <= pos_row - ROW_QUAL;
            win_col   <= pos_col - COL_QUAL;
        end else if (take) begin
            win_valid <= 1'b0;
        end
    end

    // Frame completion pulse and sticky start-of-frame error.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
        end else begin
            frame_done <= frame_end;
            sof_err    <= sof_err | discard | restart;
        end
    end

endmodule
